// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two registered read ports,
// optional hard-wired zero entry, optional write-to-read bypass, and a
// one-entry-per-cycle clear sweep so the array needs no reset and can map to RAM.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | normal operation, writes accepted, reads return entries
//   S_CLEAR | sweep zeroing entry[cnt] each edge, writes dropped, reads 0
module regfile_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_write_en,
  input  logic [ADDR_W-1:0] i_write_reg,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic [ADDR_W-1:0] i_read_reg1,
  input  logic [ADDR_W-1:0] i_read_reg2,
  output logic [DATA_W-1:0] o_read_data1,
  output logic [DATA_W-1:0] o_read_data2,
  output logic              o_busy,
  output logic              o_write_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Sweep counter stays ADDR_W wide; the last entry is detected by compare
  // so the counter never steps past the array.
  localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_clear;
  logic              wr_to_zero;
  logic              wr_accept;
  logic              wr_reject;
  logic              sweep_en;
  logic              reads_zero;
  logic [DATA_W-1:0] rd1_next;
  logic [DATA_W-1:0] rd2_next;

  // Read-port value for one address: sweep/clear and the zero entry force 0,
  // an accepted write to the same address may be forwarded, else the stored entry.
  function automatic logic [DATA_W-1:0] read_value(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              force_zero,
    input logic              wr_ok,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
  );
    logic [DATA_W-1:0] val;
    val = stored;
    if (force_zero) begin
      val = '0;
    end else if ((ZERO_REG != 0) && (addr == '0)) begin
      val = '0;
    end else if ((BYPASS != 0) && wr_ok && (addr == wr_addr)) begin
      val = wr_data;
    end
    return val;
  endfunction

  // Write qualification and read-value selection for this edge.
  always_comb begin
    in_clear   = (state == S_CLEAR);
    wr_to_zero = (ZERO_REG != 0) && (i_write_reg == '0);
    wr_accept  = !in_clear && !i_clear && i_write_en && !wr_to_zero;
    wr_reject  = i_write_en && (in_clear || i_clear);
    // A clear request arriving mid-sweep restarts the count; nothing is
    // cleared on that edge, the restarted sweep covers every entry anyway.
    sweep_en   = in_clear && !i_clear;
    reads_zero = in_clear || i_clear;
    rd1_next   = read_value(i_read_reg1, mem[i_read_reg1], reads_zero,
                            wr_accept, i_write_reg, i_write_data);
    rd2_next   = read_value(i_read_reg2, mem[i_read_reg2], reads_zero,
                            wr_accept, i_write_reg, i_write_data);
  end

  // Storage array: no reset so it can be implemented as RAM; the sweep and
  // accepted writes are mutually exclusive.
  always_ff @(posedge i_clk) begin
    if (sweep_en) begin
      mem[cnt] <= '0;
    end else if (wr_accept) begin
      mem[i_write_reg] <= i_write_data;
    end
  end

  // Sweep FSM plus registered read data, busy and drop outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= S_CLEAR;
      cnt          <= '0;
      o_busy       <= 1'b1;
      o_read_data1 <= '0;
      o_read_data2 <= '0;
      o_write_drop <= 1'b0;
    end else begin
      o_read_data1 <= rd1_next;
      o_read_data2 <= rd2_next;
      o_write_drop <= wr_reject;
      case (state)
        S_IDLE: begin
          if (i_clear) begin
            state  <= S_CLEAR;
            cnt    <= '0;
            o_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (i_clear) begin
            cnt <= '0;
          end else if (cnt == LAST_ENTRY) begin
            state  <= S_IDLE;
            cnt    <= '0;
            o_busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= S_CLEAR;
          cnt    <= '0;
          o_busy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised multi-entry register file for the FDE CPU datapath. It has one write port, two registered read ports, optional hard-wired zero entry and optional write-to-read bypass. Entries are cleared by a sequential sweep engine, one entry per cycle, after reset or on request, so the array can map to RAM. It sits between decode (read addresses) and writeback (write port).

Parameters:
DATA_W, 8, width of each entry and of read/write data
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 reads as 0 and writes to it are silently discarded; 0 = entry 0 is an ordinary entry
BYPASS, 1, 1 = a read of the address being written on the same edge returns the new data; 0 = it returns the old data

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_reset  input  1  asynchronous, active-high reset
i_clear  input  1  sampled on the rising edge; requests a full clear sweep
i_write_en  input  1  write strobe
i_write_reg  input  ADDR_W  write address
i_write_data  input  DATA_W  write data
i_read_reg1  input  ADDR_W  read port 1 address
i_read_reg2  input  ADDR_W  read port 2 address
o_read_data1  output  DATA_W  registered read data, port 1
o_read_data2  output  DATA_W  registered read data, port 2
o_busy  output  1  high while the clear sweep is in progress
o_write_drop  output  1  one-cycle registered pulse: the write presented on the previous edge was rejected

Behaviour:
- Reset (async, i_reset=1): o_read_data1/2=0, o_write_drop=0, o_busy=1, FSM=CLEAR, sweep counter=0. The array is not reset directly.
- FSM states are IDLE and CLEAR.
- CLEAR: on each edge, entry[cnt]<=0 and cnt<=cnt+1. On the edge that clears entry DEPTH-1, FSM goes to IDLE and o_busy falls after that edge.
- After reset release, o_busy stays high for exactly DEPTH rising edges.
- IDLE with i_clear=1 on an edge: FSM goes to CLEAR with cnt=0 and o_busy=1. No entry is cleared on that edge. DEPTH further edges complete the sweep.
- i_clear=1 while in CLEAR: cnt restarts at 0 and the sweep runs the full DEPTH again.
- Write accepted: an edge in IDLE with i_write_en=1 and i_clear=0, and not (ZERO_REG=1 and i_write_reg=0). Then entry[i_write_reg]<=i_write_data.
- Write rejected: i_write_en=1 on an edge while in CLEAR, or while i_clear=1. The array is unchanged and o_write_drop=1 for the next cycle.
- A write to entry 0 with ZERO_REG=1 is discarded without a drop pulse.
- In all other cases o_write_drop=0 next cycle.
- Read latency is 1 cycle. On each edge, o_read_dataN <= value(i_read_regN).
- While in CLEAR, or on the edge i_clear is sampled, value = 0.
- With ZERO_REG=1, value(0) = 0 always.
- With BYPASS=1 and an accepted write with i_write_reg == i_read_regN on the same edge, value = i_write_data.
- Otherwise value = the stored entry before this edge's write.
- Both ports may read the same address. Each port applies the bypass independently.
- Reset asserted mid-sweep or mid-write: the async return to the reset state above overrides everything. The sweep restarts from 0 after release.
- No arithmetic beyond cnt. cnt is ADDR_W+1 bits, or ADDR_W bits with an explicit last-entry compare. cnt never wraps into the array range improperly.

Test Plan:
Use DATA_W=8, ADDR_W=4 (DEPTH=16) unless noted.
- Reset: pulse i_reset, release, count edges -> o_busy=1 for exactly 16 edges then 0. Reads of every address return 8'h00. o_read_data1/2=0 during reset.
- Write/read: write 8'hA5 to r3, then read r3 on port 1 and r3 on port 2 the next cycle -> both return 8'hA5 one cycle after address is presented.
- Bypass, BYPASS=1: r5=8'h11, then same edge write r5=8'h22 and read r5 -> 8'h22. Rerun with BYPASS=0 -> 8'h11, then 8'h22 on the following read.
- Zero register: with ZERO_REG=1, write 8'hFF to r0 -> r0 reads 8'h00 and o_write_drop stays 0. With ZERO_REG=0 -> reads 8'hFF.
- Clear during traffic: fill r1..r15 with their index, assert i_clear one cycle with a write to r7=8'h77 on the same edge -> o_write_drop pulses and o_busy is high 16 cycles. Writes during busy each produce a drop. After busy falls, all entries read 8'h00.
- Restart and async reset mid-sweep: i_clear again at sweep cycle 8 -> busy extends to 16 cycles from the restart. Assert i_reset mid-sweep -> outputs 0 immediately, and busy is 16 edges after release.
